sum_frame_collector: RTL and testbench

- Downstream consumer of the 4-bit sequential adder output ({COUT,SUM}).
- Accumulates FRAME_LEN valid adder results into a wide running total.
- Presents the frame total on a valid/ready output handshake, with saturation/overflow and dropped-sample flags.
- Sits between the adder stage and any reporting or bus-facing logic.

---
 rtl/sum_frame_collector.sv | 134 +++++++++++++
 tb/tb_sum_frame_collector.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sum_frame_collector.sv
// Sums FRAME_LEN adder results ({COUT,SUM}) into a saturating frame total
// and presents it on a valid/ready handshake with overflow and dropped-sample flags.
module sum_frame_collector #(
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 8,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             IN_VALID,
  input  logic [3:0]       SUM,
  input  logic             COUT,
  input  logic             OUT_READY,
  output logic             OUT_VALID,
  output logic [ACC_W-1:0] TOTAL,
  output logic             OVF,
  output logic             DROPPED,
  output logic             BUSY,
  output logic [CNT_W-1:0] COUNT
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [ACC_W:0]   ACC_MAX  = {1'b0, {ACC_W{1'b1}}};
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             dropped_q, dropped_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [ACC_W:0]   sample_ext;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_next;
  logic             acc_sat;

  // One extra bit of headroom is enough because a sample never exceeds 31 and ACC_W >= 5.
  assign sample_ext = {{(ACC_W - 4){1'b0}}, COUT, SUM};
  assign acc_sum    = {1'b0, acc_q} + sample_ext;
  assign acc_sat    = (acc_sum > ACC_MAX);
  assign acc_next   = acc_sat ? ACC_MAX[ACC_W-1:0] : acc_sum[ACC_W-1:0];

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    total_d     = total_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    dropped_d   = dropped_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d   = ST_ACCUM;
          acc_d     = '0;
          count_d   = '0;
          ovf_d     = 1'b0;
          dropped_d = 1'b0;
          busy_d    = 1'b1;
        end else if (IN_VALID) begin
          dropped_d = 1'b1;
        end
      end

      ST_ACCUM: begin
        if (IN_VALID) begin
          acc_d   = acc_next;
          count_d = count_q + CNT_W'(1);
          if (acc_sat) ovf_d = 1'b1;
          // The sample that fills the frame goes straight into TOTAL on the same edge.
          if (count_q == LAST_IDX) begin
            state_d     = ST_DONE;
            total_d     = acc_next;
            out_valid_d = 1'b1;
            busy_d      = 1'b0;
          end
        end
      end

      ST_DONE: begin
        if (IN_VALID) dropped_d = 1'b1;
        if (OUT_READY) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      total_q     <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      dropped_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      total_q     <= total_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      dropped_q   <= dropped_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign TOTAL     = total_q;
  assign OVF       = ovf_q;
  assign DROPPED   = dropped_q;
  assign BUSY      = busy_q;
  assign COUNT     = count_q;

endmodule

// File: tb/tb_sum_frame_collector.sv
// Directed self-checking bench for sum_frame_collector: a default 8x8 instance
// and a 4-sample, 6-bit instance for saturation.
module tb_sum_frame_collector;

  logic       CLK;
  logic       RST_N;

  logic       start, in_valid, cout, out_ready;
  logic [3:0] sum;
  logic       out_valid, ovf, dropped, busy;
  logic [7:0] total;
  logic [3:0] count;

  logic       s_start, s_in_valid, s_cout, s_out_ready;
  logic [3:0] s_sum;
  logic       s_out_valid, s_ovf, s_dropped, s_busy;
  logic [5:0] s_total;
  logic [2:0] s_count;

  int vec_count   = 0;
  int miscompares = 0;

  sum_frame_collector #(.FRAME_LEN(8), .ACC_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(start), .IN_VALID(in_valid),
    .SUM(sum), .COUT(cout), .OUT_READY(out_ready),
    .OUT_VALID(out_valid), .TOTAL(total), .OVF(ovf),
    .DROPPED(dropped), .BUSY(busy), .COUNT(count)
  );

  sum_frame_collector #(.FRAME_LEN(4), .ACC_W(6)) dut_sat (
    .CLK(CLK), .RST_N(RST_N), .START(s_start), .IN_VALID(s_in_valid),
    .SUM(s_sum), .COUT(s_cout), .OUT_READY(s_out_ready),
    .OUT_VALID(s_out_valid), .TOTAL(s_total), .OVF(s_ovf),
    .DROPPED(s_dropped), .BUSY(s_busy), .COUNT(s_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic iv, input logic co,
                               input logic [3:0] sm, input logic rdy);
    start     = st;
    in_valid  = iv;
    cout      = co;
    sum       = sm;
    out_ready = rdy;
    tick();
  endtask

  task automatic applySatStimulus(input logic st, input logic iv, input logic co,
                                  input logic [3:0] sm, input logic rdy);
    s_start     = st;
    s_in_valid  = iv;
    s_cout      = co;
    s_sum       = sm;
    s_out_ready = rdy;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    start = 0; in_valid = 0; cout = 0; sum = 0; out_ready = 0;
    s_start = 0; s_in_valid = 0; s_cout = 0; s_sum = 0; s_out_ready = 0;

    #3;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_total", total, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_dropped", dropped, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_count", count, 0);
    #4 RST_N = 1'b1;
    tick();

    // Abort a frame after three samples with an asynchronous reset.
    applyStimulus(1, 0, 0, 4'd0, 0);
    checkOutput("start_busy", busy, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 4'd1, 0);
    checkOutput("partial_count", count, 3);
    start = 0; in_valid = 0;
    #2 RST_N = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_count", count, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    #2 RST_N = 1'b1;
    tick();

    applyStimulus(1, 0, 0, 4'd0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 4'd1, 0);
    checkOutput("ones_not_done", out_valid, 0);
    applyStimulus(0, 1, 0, 4'd1, 0);
    checkOutput("ones_out_valid", out_valid, 1);
    checkOutput("ones_total", total, 8);
    checkOutput("ones_ovf", ovf, 0);
    checkOutput("ones_busy", busy, 0);
    applyStimulus(0, 0, 0, 4'd0, 1);
    checkOutput("ones_accept", out_valid, 0);

    // Eight samples of 5 separated by idle cycles.
    applyStimulus(1, 0, 0, 4'd0, 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 1, 0, 4'd5, 0);
      applyStimulus(0, 0, 0, 4'd0, 0);
    end
    checkOutput("fives_count7", count, 7);
    checkOutput("fives_not_done", out_valid, 0);
    applyStimulus(0, 1, 0, 4'd5, 0);
    checkOutput("fives_out_valid", out_valid, 1);
    checkOutput("fives_total", total, 40);
    checkOutput("fives_ovf", ovf, 0);
    checkOutput("fives_count", count, 8);
    applyStimulus(0, 0, 0, 4'd0, 1);
    checkOutput("fives_accept", out_valid, 0);
    checkOutput("fives_dropped", dropped, 0);

    // IDLE sample flags DROPPED; the START-cycle sample is ignored and START clears it.
    applyStimulus(0, 1, 0, 4'd3, 0);
    checkOutput("idle_dropped", dropped, 1);
    applyStimulus(1, 1, 1, 4'hF, 0);
    checkOutput("startcyc_dropped", dropped, 0);
    checkOutput("startcyc_count", count, 0);
    checkOutput("startcyc_busy", busy, 1);
    checkOutput("startcyc_total_held", total, 40);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 4'd2, 0);
    checkOutput("twos_out_valid", out_valid, 1);
    checkOutput("twos_total", total, 16);
    checkOutput("twos_count", count, 8);
    applyStimulus(0, 0, 0, 4'd0, 1);
    checkOutput("twos_accept", out_valid, 0);

    // Maximum samples with carry set, then backpressure in DONE.
    applyStimulus(1, 0, 0, 4'd0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 4'hF, 0);
    checkOutput("max_out_valid", out_valid, 1);
    checkOutput("max_total", total, 248);
    checkOutput("max_ovf", ovf, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i == 1, i == 2, 0, 4'd7, 0);
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_total", total, 248);
      checkOutput("bp_busy", busy, 0);
    end
    checkOutput("bp_dropped", dropped, 1);
    applyStimulus(0, 0, 0, 4'd0, 1);
    checkOutput("bp_accept", out_valid, 0);
    checkOutput("bp_total_kept", total, 248);
    checkOutput("bp_dropped_kept", dropped, 1);
    applyStimulus(1, 0, 0, 4'd0, 0);
    checkOutput("restart_dropped", dropped, 0);
    checkOutput("restart_busy", busy, 1);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 4'd0, 0);
    checkOutput("zeros_total", total, 0);
    checkOutput("zeros_out_valid", out_valid, 1);
    applyStimulus(0, 0, 0, 4'd0, 1);

    // Saturation on the 6-bit, 4-sample instance: 31, 62, then clamps at 63.
    applySatStimulus(1, 0, 0, 4'd0, 0);
    applySatStimulus(0, 1, 1, 4'hF, 0);
    applySatStimulus(0, 1, 1, 4'hF, 0);
    checkOutput("sat_ovf_2", s_ovf, 0);
    applySatStimulus(0, 1, 1, 4'hF, 0);
    checkOutput("sat_ovf_3", s_ovf, 1);
    checkOutput("sat_not_done", s_out_valid, 0);
    applySatStimulus(0, 1, 1, 4'hF, 0);
    checkOutput("sat_out_valid", s_out_valid, 1);
    checkOutput("sat_total", s_total, 63);
    checkOutput("sat_ovf", s_ovf, 1);
    checkOutput("sat_count", s_count, 4);
    applySatStimulus(0, 0, 0, 4'd0, 1);
    checkOutput("sat_accept", s_out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
